// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear FSM encodings and default geometry.
package reg_file_mp_pkg;

   localparam logic RF_IDLE     = 1'b0;
   localparam logic RF_CLEARING = 1'b1;

   localparam int unsigned RF_DEF_WIDTH = 8;
   localparam int unsigned RF_DEF_DEPTH = 8;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Sequential clear engine: walks an index from 0 to DEPTH-1, one register per cycle.
module reg_file_clear_fsm
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned DEPTH = RF_DEF_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clear,
   output logic          o_busy,
   output logic          o_clr_en,
   output logic [AW-1:0] o_clr_idx
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic          r_state;
   logic [AW-1:0] r_idx;
   logic          w_busy;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= RF_IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            RF_IDLE: begin
               if (i_clear) begin
                  r_state <= RF_CLEARING;
                  r_idx   <= '0;
               end
            end
            default: begin
               // Terminal compare instead of wrap: the last index ends the sweep.
               if (r_idx == LAST_IDX) begin
                  r_state <= RF_IDLE;
               end else begin
                  r_idx <= r_idx + AW'(1);
               end
            end
         endcase
      end
   end

   assign w_busy    = (r_state == RF_CLEARING);
   assign o_busy    = w_busy;
   assign o_clr_en  = w_busy;
   assign o_clr_idx = r_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write bypass, per-register pending scoreboard and
// a sequential clear engine.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned WIDTH    = RF_DEF_WIDTH,
   parameter int unsigned DEPTH    = RF_DEF_DEPTH,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic [WIDTH-1:0]                 IN,
   input  logic [$clog2(DEPTH)-1:0]         INADDRESS,
   input  logic                             WRITE,
   input  logic [NREAD*$clog2(DEPTH)-1:0]   RADDR,
   output logic [NREAD*WIDTH-1:0]           OUT,
   input  logic                             RESERVE,
   input  logic [$clog2(DEPTH)-1:0]         RESADDRESS,
   output logic [NREAD-1:0]                 PENDING,
   input  logic                             CLEAR,
   output logic                             BUSY
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_pend;

   logic          w_busy;
   logic          w_clr_en;
   logic [AW-1:0] w_clr_idx;
   logic          w_wr;
   logic          w_rsv;

   reg_file_clear_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_fsm (
      .i_clk     (CLK),
      .i_rst_n   (RESET),
      .i_clear   (CLEAR),
      .o_busy    (w_busy),
      .o_clr_en  (w_clr_en),
      .o_clr_idx (w_clr_idx)
   );

   // Writes and reserves are dropped outright while clearing, and never touch r0 in ZERO_REG mode.
   assign w_wr  = WRITE && !w_busy && !((ZERO_REG != 0) && (INADDRESS == '0));
   assign w_rsv = RESERVE && !w_busy && !((ZERO_REG != 0) && (RESADDRESS == '0));

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_pend <= '0;
      end else if (w_clr_en) begin
         r_mem[w_clr_idx]  <= '0;
         r_pend[w_clr_idx] <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[INADDRESS]  <= IN;
            r_pend[INADDRESS] <= 1'b0;
         end
         // Later assignment wins: a reserve marks the newer producer over a same-cycle write.
         if (w_rsv) begin
            r_pend[RESADDRESS] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_zero;
      logic          w_byp;

      assign w_ra   = RADDR[k*AW +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
      assign w_byp  = (BYPASS != 0) && w_wr && (INADDRESS == w_ra);

      assign OUT[k*WIDTH +: WIDTH] = w_zero ? '0 : (w_byp ? IN : r_mem[w_ra]);
      assign PENDING[k]            = !w_zero && r_pend[w_ra];
   end

   assign BUSY = w_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two default-geometry instances (bypass on/off) checked every cycle
// against a behavioural model, plus a wide ZERO_REG instance with directed checks.
module tb_reg_file_mp;

   logic        clk;
   logic        rst_n;
   logic [7:0]  din;
   logic [2:0]  waddr;
   logic        wr;
   logic [5:0]  raddr;
   logic        rsv;
   logic [2:0]  resaddr;
   logic        clr;

   logic [15:0] a_out, b_out;
   logic [1:0]  a_pend, b_pend;
   logic        a_busy, b_busy;

   logic        c_rst_n;
   logic [15:0] c_in;
   logic [4:0]  c_waddr;
   logic        c_wr;
   logic [14:0] c_raddr;
   logic [47:0] c_out;
   logic        c_rsv;
   logic [4:0]  c_resaddr;
   logic [2:0]  c_pend;
   logic        c_clr;
   logic        c_busy;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 0;
   int nb;

   // Behavioural model of the default-geometry register file.
   logic [7:0] m_mem [8];
   logic       m_pend [8];
   int         m_cnt;

   reg_file_mp #(.BYPASS(1)) u_a (
      .CLK(clk), .RESET(rst_n), .IN(din), .INADDRESS(waddr), .WRITE(wr), .RADDR(raddr),
      .OUT(a_out), .RESERVE(rsv), .RESADDRESS(resaddr), .PENDING(a_pend), .CLEAR(clr),
      .BUSY(a_busy)
   );

   reg_file_mp #(.BYPASS(0)) u_b (
      .CLK(clk), .RESET(rst_n), .IN(din), .INADDRESS(waddr), .WRITE(wr), .RADDR(raddr),
      .OUT(b_out), .RESERVE(rsv), .RESADDRESS(resaddr), .PENDING(b_pend), .CLEAR(clr),
      .BUSY(b_busy)
   );

   reg_file_mp #(.WIDTH(16), .DEPTH(32), .NREAD(3), .BYPASS(1), .ZERO_REG(1)) u_c (
      .CLK(clk), .RESET(c_rst_n), .IN(c_in), .INADDRESS(c_waddr), .WRITE(c_wr),
      .RADDR(c_raddr), .OUT(c_out), .RESERVE(c_rsv), .RESADDRESS(c_resaddr),
      .PENDING(c_pend), .CLEAR(c_clr), .BUSY(c_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_out(input bit byp, input int k);
      logic [2:0] ra;
      ra = raddr[k*3 +: 3];
      if (byp && m_cnt == 0 && wr && waddr == ra) return din;
      return m_mem[ra];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            m_mem[i]  = 8'h00;
            m_pend[i] = 1'b0;
         end
         m_cnt = 0;
      end else if (m_cnt > 0) begin
         m_mem[8 - m_cnt]  = 8'h00;
         m_pend[8 - m_cnt] = 1'b0;
         m_cnt--;
      end else begin
         if (wr) begin
            m_mem[waddr]  = din;
            m_pend[waddr] = 1'b0;
         end
         if (rsv) m_pend[resaddr] = 1'b1;
         if (clr) m_cnt = 8;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("model_a_out", a_out[k*8 +: 8], exp_out(1'b1, k));
            chk("model_b_out", b_out[k*8 +: 8], exp_out(1'b0, k));
            chk("model_a_pend", a_pend[k], m_pend[raddr[k*3 +: 3]]);
            chk("model_b_pend", b_pend[k], m_pend[raddr[k*3 +: 3]]);
         end
         chk("model_a_busy", a_busy, m_cnt > 0);
         chk("model_b_busy", b_busy, m_cnt > 0);
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
      adv();
      wr = 1'b1; waddr = a; din = d;
      settle();
      adv();
      wr = 1'b0;
      settle();
   endtask

   task automatic wr_c(input logic [4:0] a, input logic [15:0] d);
      adv();
      c_wr = 1'b1; c_waddr = a; c_in = d;
      settle();
      adv();
      c_wr = 1'b0;
      settle();
   endtask

   task automatic chk_all_zero(input string nm);
      for (int i = 0; i < 8; i++) begin
         raddr = {3'(7 - i), 3'(i)};
         settle();
         chk(nm, a_out, 16'h0000);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; din = '0; waddr = '0; wr = 1'b0; raddr = '0; rsv = 1'b0;
      resaddr = '0; clr = 1'b0;
      c_rst_n = 1'b0; c_in = '0; c_waddr = '0; c_wr = 1'b0; c_raddr = '0; c_rsv = 1'b0;
      c_resaddr = '0; c_clr = 1'b0;
      settle();
      adv();
      rst_n = 1'b1; c_rst_n = 1'b1; chk_en = 1'b1;

      // Reset after arbitrary contents.
      for (int i = 0; i < 8; i++) wr_a(3'(i), 8'($urandom_range(1, 255)));
      adv();
      rsv = 1'b1; resaddr = 3'd6;
      adv();
      rsv = 1'b0; rst_n = 1'b0;
      settle();
      adv();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         raddr = {3'(7 - i), 3'(i)};
         settle();
         chk("reset_out", a_out, 16'h0000);
         chk("reset_pend", a_pend, 2'b00);
         chk("reset_busy", a_busy, 1'b0);
      end

      // Write with bypass versus no bypass.
      raddr = {3'd0, 3'd3};
      adv();
      wr = 1'b1; waddr = 3'd3; din = 8'hA5;
      settle();
      chk("bypass_same_cycle", a_out[7:0], 8'hA5);
      chk("nobypass_same_cycle", b_out[7:0], 8'h00);
      adv();
      wr = 1'b0;
      settle();
      chk("bypass_next_cycle", a_out[7:0], 8'hA5);
      chk("nobypass_next_cycle", b_out[7:0], 8'hA5);

      // Scoreboard.
      raddr = {3'd0, 3'd5};
      adv();
      rsv = 1'b1; resaddr = 3'd5;
      settle();
      chk("pend_before_reserve", a_pend[0], 1'b0);
      adv();
      rsv = 1'b0;
      settle();
      chk("pend_after_reserve", a_pend[0], 1'b1);
      adv();
      wr = 1'b1; waddr = 3'd5; din = 8'h11;
      settle();
      chk("pend_not_bypassed", a_pend[0], 1'b1);
      adv();
      wr = 1'b0;
      settle();
      chk("pend_after_write", a_pend[0], 1'b0);
      adv();
      wr = 1'b1; rsv = 1'b1; waddr = 3'd5; resaddr = 3'd5; din = 8'h11;
      settle();
      adv();
      wr = 1'b0; rsv = 1'b0;
      settle();
      chk("pend_reserve_wins", a_pend[0], 1'b1);
      chk("data_reserve_write", a_out[7:0], 8'h11);

      // Full clear with a dropped mid-clear write.
      for (int i = 0; i < 8; i++) wr_a(3'(i), 8'(i + 1));
      raddr = {3'd7, 3'd0};
      adv();
      clr = 1'b1;
      settle();
      chk("busy_not_yet", a_busy, 1'b0);
      adv();
      clr = 1'b0;
      nb = 0;
      for (int c = 0; c < 20; c++) begin
         settle();
         if (a_busy) nb++;
         else if (nb > 0) break;
         if (a_busy && nb == 1) chk("clear_r0_first_cycle", a_out[7:0], 8'h01);
         if (a_busy && nb == 2) begin
            chk("clear_r0_done", a_out[7:0], 8'h00);
            chk("clear_r7_untouched", a_out[15:8], 8'h08);
         end
         adv();
         wr = (nb == 1); waddr = 3'd7; din = 8'hFF;
      end
      wr = 1'b0;
      chk("clear_busy_len", 64'(nb), 64'd8);
      chk_all_zero("clear_all_zero");

      // Reset during a clear.
      for (int i = 0; i < 8; i++) wr_a(3'(i), 8'(i + 1));
      adv();
      clr = 1'b1;
      settle();
      adv();
      clr = 1'b0;
      nb = 0;
      for (int c = 0; c < 20; c++) begin
         settle();
         if (a_busy) nb++;
         if (nb == 4) break;
         adv();
         rst_n = (nb != 3);
      end
      chk("midclear_reached_4", 64'(nb), 64'd4);
      adv();
      rst_n = 1'b1;
      settle();
      chk("midclear_busy_drop", a_busy, 1'b0);
      chk_all_zero("midclear_all_zero");
      wr_a(3'd2, 8'h5A);
      raddr = {3'd0, 3'd2};
      settle();
      chk("post_reset_write", a_out[7:0], 8'h5A);

      // Wide instance with zero register.
      wr_c(5'd1, 16'h1111);
      wr_c(5'd17, 16'h2222);
      wr_c(5'd31, 16'h3333);
      c_raddr = {5'd31, 5'd17, 5'd1};
      settle();
      chk("c_port0", c_out[15:0], 16'h1111);
      chk("c_port1", c_out[31:16], 16'h2222);
      chk("c_port2", c_out[47:32], 16'h3333);
      adv();
      c_wr = 1'b1; c_waddr = 5'd17; c_in = 16'hABCD;
      settle();
      chk("c_bypass_port1", c_out[31:16], 16'hABCD);
      adv();
      c_wr = 1'b0;
      c_raddr = {5'd31, 5'd17, 5'd0};
      adv();
      c_wr = 1'b1; c_waddr = 5'd0; c_in = 16'hFFFF;
      settle();
      chk("c_zero_bypass", c_out[15:0], 16'h0000);
      adv();
      c_wr = 1'b0;
      settle();
      chk("c_zero_read", c_out[15:0], 16'h0000);
      adv();
      c_rsv = 1'b1; c_resaddr = 5'd0;
      settle();
      adv();
      c_rsv = 1'b0;
      settle();
      chk("c_zero_pend", c_pend[0], 1'b0);
      adv();
      c_rsv = 1'b1; c_resaddr = 5'd31;
      settle();
      adv();
      c_rsv = 1'b0;
      settle();
      chk("c_pend_r31", c_pend[2], 1'b1);
      chk("c_pend_r17", c_pend[1], 1'b0);
      chk("c_busy_idle", c_busy, 1'b0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
